// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// reset PC, PC step, RV32I opcode constants and a PC alignment helper.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_HOLD   = 2'd2,
    FETCH_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Opcode field values (inst[6:0]) shared with the control unit
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Force an address onto a word boundary
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode/datapath side.
interface inst_fetch_unit_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        halted;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready, redirect_valid, redirect_target, halt,
    output halted
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready, redirect_valid, redirect_target, halt,
    input  halted
  );

endinterface

// File: rtl/inst_fetch_unit_fetch_pc.sv
// Program counter register: synchronous reset to RESET_PC, +4 step that
// wraps modulo 2^32, and word-aligned redirect load (load wins over step).
module inst_fetch_unit_fetch_pc
  import inst_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Select the next PC: redirect target, sequential step, or hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = pc_align(target_i);
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction
// memory, buffers the returned word in a single entry, and presents it to
// decode. Redirects discard any in-flight response; halt freezes fetch
// until reset.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  inst_fetch_unit_if.master  bus
);

  fetch_state_e state_q;
  logic         req_valid_q;
  logic         inst_valid_q;
  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;
  logic         drop_q;
  logic         halted_q;

  logic [31:0]  pc;
  logic         pc_inc;
  logic         pc_load;
  logic         req_fire;
  logic         consume;
  logic         halt_fire;

  assign req_fire  = req_valid_q & bus.imem_req_ready;
  assign consume   = inst_valid_q & bus.inst_ready;
  assign halt_fire = consume & bus.halt;

  inst_fetch_unit_fetch_pc u_fetch_pc (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (pc_inc),
    .load_i   (pc_load),
    .target_i (bus.redirect_target),
    .pc_o     (pc)
  );

  // Decide when the PC steps or reloads; halt beats redirect beats consume
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      FETCH_HALTED: begin
        pc_inc  = 1'b0;
        pc_load = 1'b0;
      end
      FETCH_HOLD: begin
        if (!halt_fire) begin
          if (bus.redirect_valid) begin
            pc_load = 1'b1;
          end else if (consume) begin
            pc_inc = 1'b1;
          end
        end
      end
      default: begin
        pc_load = bus.redirect_valid;
      end
    endcase
  end

  // Fetch FSM with registered request/instruction/halt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_REQ;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      drop_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (req_fire) begin
            state_q     <= FETCH_WAIT;
            req_valid_q <= 1'b0;
            drop_q      <= bus.redirect_valid;
          end
        end
        FETCH_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (drop_q || bus.redirect_valid) begin
              state_q     <= FETCH_REQ;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              state_q      <= FETCH_HOLD;
              inst_valid_q <= 1'b1;
              inst_q       <= bus.imem_resp_data;
              inst_pc_q    <= pc;
            end
          end else if (bus.redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (halt_fire) begin
            state_q      <= FETCH_HALTED;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b1;
          end else if (bus.redirect_valid || consume) begin
            state_q      <= FETCH_REQ;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b1;
          end
        end
        FETCH_HALTED: begin
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          halted_q     <= 1'b1;
        end
        default: begin
          state_q     <= FETCH_REQ;
          req_valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.halted         = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: bench-side memory, a transaction-level PC
// model checked every cycle, and directed scenarios with literal values.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  inst_fetch_unit_if bus();

  inst_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents: 0x13 (nop) at address 0, a distinct pattern elsewhere
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'h1234_5678);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic reqReady, input logic instReady,
                               input logic redirect, input logic [31:0] target,
                               input logic haltIn);
    bus.imem_req_ready  = reqReady;
    bus.inst_ready      = instReady;
    bus.redirect_valid  = redirect;
    bus.redirect_target = target;
    bus.halt            = haltIn;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitInstValid(input int maxCycles);
    int n = 0;
    while (bus.inst_valid !== 1'b1 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_inst_valid: got timeout after %0d cycles, expected inst_valid", n);
    end
  endtask

  // Instruction memory: answers each accepted request after extraWait+1 cycles
  int          extraWait      = 0;
  int          acceptCount    = 0;
  logic [31:0] lastAcceptAddr = 32'h0;
  logic        memPend        = 1'b0;
  logic [31:0] memPendAddr    = 32'h0;
  int          memWait        = 0;
  logic        sawAccept;
  logic        sawResp;

  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      sawAccept = bus.imem_req_valid && bus.imem_req_ready && !reset;
      sawResp   = bus.imem_resp_valid;
      if (reset || sawResp) memPend = 1'b0;
      if (sawAccept) begin
        memPend        = 1'b1;
        memPendAddr    = bus.imem_req_addr;
        memWait        = extraWait;
        acceptCount++;
        lastAcceptAddr = bus.imem_req_addr;
      end
      #1;
      if (memPend && memWait == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memWord(memPendAddr);
      end else begin
        if (memPend) memWait--;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Transaction-level model: where fetch must be, and whether it is halted
  logic [31:0] expPc      = 32'h0;
  logic        haltedM    = 1'b0;
  int          deliveries = 0;

  always @(posedge clk) begin
    if (reset) begin
      expPc   = 32'h0;
      haltedM = 1'b0;
    end else if (!haltedM) begin
      if (bus.inst_valid && bus.inst_ready) deliveries++;
      if (bus.halt && bus.inst_valid && bus.inst_ready) haltedM = 1'b1;
      else if (bus.redirect_valid) expPc = {bus.redirect_target[31:2], 2'b00};
      else if (bus.inst_valid && bus.inst_ready) expPc = expPc + 32'd4;
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checkOutput("cmp_halted", {31'b0, bus.halted}, {31'b0, haltedM});
      if (haltedM) begin
        checkOutput("cmp_halt_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        checkOutput("cmp_halt_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      end
      if (bus.imem_req_valid) checkOutput("cmp_req_addr", bus.imem_req_addr, expPc);
      if (bus.inst_valid) begin
        checkOutput("cmp_inst_pc", bus.inst_pc, expPc);
        checkOutput("cmp_inst", bus.inst, memWord(expPc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  int snapAcc;
  int snapDel;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(2);
    reset = 1'b0;

    // Reset values, cycle 1 after reset
    checkOutput("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    checkOutput("rst_req_addr", bus.imem_req_addr, 32'h0);
    checkOutput("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("rst_inst", bus.inst, 32'h0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
    checkOutput("rst_halted", {31'b0, bus.halted}, 32'h0);

    // Zero-wait latency: WAIT on cycle 2, HOLD on cycle 3
    tick(1);
    checkOutput("lat_c2_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    checkOutput("lat_c2_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    tick(1);
    checkOutput("lat_c3_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("lat_c3_inst", bus.inst, 32'h0000_0013);
    checkOutput("lat_c3_inst_pc", bus.inst_pc, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("next_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    checkOutput("next_req_addr", bus.imem_req_addr, 32'h4);

    // Memory not ready for 4 cycles: address held, one request, one inst
    snapAcc = acceptCount;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
      checkOutput("stall_req_addr", bus.imem_req_addr, 32'h4);
    end
    checkOutput("stall_no_accept", 32'(acceptCount - snapAcc), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    waitInstValid(20);
    checkOutput("stall_one_accept", 32'(acceptCount - snapAcc), 32'h1);
    checkOutput("stall_inst_pc", bus.inst_pc, 32'h4);
    checkOutput("stall_inst", bus.inst, 32'h1234_567C);

    // Decode stalls 5 cycles in HOLD: buffer stable, no request
    snapDel = deliveries;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("hold_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
      checkOutput("hold_inst_pc", bus.inst_pc, 32'h4);
      checkOutput("hold_inst", bus.inst, 32'h1234_567C);
      checkOutput("hold_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    end
    checkOutput("hold_one_accept", 32'(acceptCount - snapAcc), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1);
    checkOutput("hold_done_req_addr", bus.imem_req_addr, 32'h8);
    checkOutput("hold_one_delivery", 32'(deliveries - snapDel), 32'h1);

    // Redirect while waiting on a slow response: response dropped
    extraWait = 2;
    tick(1);
    checkOutput("rdw_in_wait", {31'b0, bus.imem_req_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    extraWait = 0;
    checkOutput("rdw_still_wait", {31'b0, bus.imem_req_valid}, 32'h0);
    waitInstValid(20);
    checkOutput("rdw_inst_pc", bus.inst_pc, 32'h0000_0100);
    checkOutput("rdw_inst", bus.inst, 32'h1234_5778);
    checkOutput("rdw_accept_addr", lastAcceptAddr, 32'h0000_0100);

    // Redirect in the same cycle as the response: response dropped
    tick(1);
    checkOutput("rdr_req_addr", bus.imem_req_addr, 32'h0000_0104);
    tick(1);
    checkOutput("rdr_in_wait", {31'b0, bus.imem_req_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rdr_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    checkOutput("rdr_req_addr2", bus.imem_req_addr, 32'h0000_0200);
    checkOutput("rdr_inst_valid", {31'b0, bus.inst_valid}, 32'h0);

    // Redirect in HOLD beats inst_ready; then wrap past 0xFFFF_FFFC
    waitInstValid(20);
    checkOutput("rdh_inst_pc", bus.inst_pc, 32'h0000_0200);
    checkOutput("rdh_inst", bus.inst, 32'h1234_5478);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rdh_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("rdh_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    waitInstValid(20);
    checkOutput("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_inst", bus.inst, 32'hEDCB_A984);
    tick(1);
    checkOutput("wrap_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    checkOutput("wrap_req_addr", bus.imem_req_addr, 32'h0);

    // Halt together with redirect: halt wins, fetch stops for good
    waitInstValid(20);
    checkOutput("halt_inst_pc", bus.inst_pc, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("halt_halted", {31'b0, bus.halted}, 32'h1);
    checkOutput("halt_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    checkOutput("halt_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    snapAcc = acceptCount;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("halted_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
      checkOutput("halted_stays", {31'b0, bus.halted}, 32'h1);
    end
    checkOutput("halted_no_accept", 32'(acceptCount - snapAcc), 32'h0);

    // Reset leaves HALTED, then reset in WAIT drops the response
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("rst2_halted", {31'b0, bus.halted}, 32'h0);
    checkOutput("rst2_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    checkOutput("rst2_req_addr", bus.imem_req_addr, 32'h0);
    waitInstValid(20);
    checkOutput("rst2_inst_pc", bus.inst_pc, 32'h0);
    tick(1);
    checkOutput("rstw_req_addr", bus.imem_req_addr, 32'h4);
    tick(1);
    checkOutput("rstw_in_wait", {31'b0, bus.imem_req_valid}, 32'h0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("rstw_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("rstw_inst", bus.inst, 32'h0);
    checkOutput("rstw_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    checkOutput("rstw_req_addr2", bus.imem_req_addr, 32'h0);
    waitInstValid(20);
    checkOutput("rstw_inst_pc", bus.inst_pc, 32'h0);
    checkOutput("rstw_inst2", bus.inst, 32'h0000_0013);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have the ports below; one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 imem_req_valid  out  1  fetch request to instruction memory.
REQ-005 imem_req_addr  out  32  word-aligned fetch address (= pc).
REQ-006 imem_req_ready  in  1  memory accepts request this cycle.
REQ-007 imem_resp_valid  in  1  memory returns data this cycle.
REQ-008 imem_resp_data  in  32  fetched instruction word.
REQ-009 inst_valid  out  1  instruction available to decode/control unit.
REQ-010 inst  out  32  buffered instruction; inst[6:0] is the opcode field.
REQ-011 inst_pc  out  32  address of inst.
REQ-012 inst_ready  in  1  decode consumes inst this cycle.
REQ-013 redirect_valid  in  1  taken branch / jal / jalr from datapath.
REQ-014 redirect_target  in  32  next PC on redirect; bits [1:0] ignored.
REQ-015 halt  in  1  ecall-halt condition for the instruction currently presented.
REQ-016 halted  out  1  fetch stopped; held until reset.

Function
REQ-017 States: REQ, WAIT, HOLD, HALTED; reset state REQ.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-019 WAIT: on imem_resp_valid, capture imem_resp_data and pc into the 1-entry buffer -> HOLD; no new request issued.
REQ-020 HOLD: inst_valid=1; on inst_ready with no redirect and no halt, pc <= pc+4, -> REQ.
REQ-021 Handshake rules: a request is accepted only when imem_req_valid&imem_req_ready; inst, inst_pc, inst_valid stable until inst_ready or redirect.
REQ-022 pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-023 redirect_valid in any state except HALTED: pc <= {redirect_target[31:2],2'b00}, inst_valid cleared next cycle, -> REQ; redirect has priority over inst_ready.
REQ-024 redirect in WAIT: state -> REQ only after the outstanding response arrives; that response is discarded (drop flag), then fetch from the new pc.
REQ-025 Redirect and imem_resp_valid in the same WAIT cycle: response discarded, -> REQ.
REQ-026 halt&inst_valid&inst_ready -> HALTED; halt has priority over redirect; halt ignored when inst_valid=0.
REQ-027 HALTED: halted=1, imem_req_valid=0, inst_valid=0; exits only via reset.
REQ-028 imem_resp_valid outside WAIT is ignored.
REQ-029 Latency: minimum 3 cycles request-to-inst_valid with zero-wait memory (REQ, WAIT, HOLD).

Reset
REQ-030 reset: pc=RESET_PC (32'h0000_0000), state REQ, buffer invalid, drop flag clear.
REQ-031 Reset outputs: imem_req_valid=1 in first post-reset cycle, imem_req_addr=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
REQ-032 Reset asserted mid-WAIT: outstanding response is not captured; fetch restarts at 0.

Structure
REQ-033 Shared package holds the state encoding, RESET_PC, and the opcode constants already used by the control unit.
REQ-034 One sub-module natural: fetch_pc (PC register with sync reset, increment and redirect load).
REQ-035 Implementation scope 120-400 lines RTL; no latches, no combinational path from imem_resp_* to inst_*.

Verification
REQ-036 Reset, zero-wait memory returning 0x00000013 at addr 0 -> inst_valid on cycle 3, inst=0x00000013, inst_pc=0, next request addr 4.
REQ-037 imem_req_ready low 4 cycles -> imem_req_addr held constant, single request accepted, single inst delivered.
REQ-038 inst_ready low 5 cycles in HOLD -> inst/inst_pc stable, no new request issued.
REQ-039 redirect_valid in WAIT with target 0x100 -> pending response dropped, next accepted request addr 0x100, next inst_pc=0x100.
REQ-040 halt=1 with inst_valid&inst_ready and simultaneous redirect -> halted=1 next cycle, no further requests until reset.
REQ-041 pc at 0xFFFF_FFFC consumed -> next request addr 0x0000_0000; reset mid-WAIT -> response ignored, request addr 0.
